rc5_key_mixer: RTL and testbench

Second stage of the RC5 key schedule: takes the c-word secret-key array L produced by the byte-to-word conversion stage, builds the t = 2(r+1) word expanded table S from the magic constants P and Q, and runs the 3·max(t,c) mixing loop over S and L. The finished S table is exposed through a read port to the encrypt/decrypt datapath. The block runs entirely on clk2, the same clock that drives the L-word writes from the upstream stage.

---
 rtl/rc5_key_mixer.sv | 171 +++++++++++++++++
 tb/tb_rc5_key_mixer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_key_mixer.sv
// RC5 key schedule, second stage: fills S from P/Q, then runs the 3*max(t,c) mix over S and L.
// The finished S table is read combinationally through s_raddr/s_rdata.
module rc5_key_mixer #(
    parameter int w        = 32,
    parameter int w_length = 5,
    parameter int r        = 12,
    parameter int t        = 26,
    parameter int t_length = 5,
    parameter int c        = 4,
    parameter int c_length = 2,
    parameter logic [w-1:0] P = 32'hB7E15163,
    parameter logic [w-1:0] Q = 32'h9E3779B9
) (
    input  logic                clk2,
    input  logic                rst,
    input  logic                l_we,
    input  logic [c_length-1:0] l_addr,
    input  logic [w-1:0]        l_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                key_valid,
    input  logic [t_length-1:0] s_raddr,
    output logic [w-1:0]        s_rdata
);

    // t is 2(r+1); the mix length is taken from the round count so both stay tied together
    localparam int table_size = 2 * (r + 1);
    localparam int mix_iters  = 3 * ((table_size > c) ? table_size : c);
    localparam int k_width    = $clog2(mix_iters + 1);

    localparam logic [t_length-1:0] i_last = t_length'(t - 1);
    localparam logic [c_length-1:0] j_last = c_length'(c - 1);
    localparam logic [k_width-1:0]  k_last = k_width'(mix_iters - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MIX,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [w-1:0]         s_q [t];
    logic [w-1:0]         s_d [t];
    logic [w-1:0]         l_q [c];
    logic [w-1:0]         l_d [c];
    logic [w-1:0]         a_q, a_d;
    logic [w-1:0]         b_q, b_d;
    logic [t_length-1:0]  i_q, i_d;
    logic [c_length-1:0]  j_q, j_d;
    logic [k_width-1:0]   k_q, k_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 key_valid_q, key_valid_d;
    logic [w-1:0]         a_new;
    logic [w-1:0]         b_new;

    function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [w_length-1:0] n);
        return (n == '0) ? x : ((x << n) | (x >> (w - int'(n))));
    endfunction

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        l_d         = l_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;

        a_new = rotl(s_q[i_q] + a_q + b_q, w_length'(3));
        b_new = rotl(l_q[j_q] + a_new + b_q, w_length'(a_new + b_q));

        unique case (state_q)
            ST_IDLE: begin
                // the write lands before a same-cycle start, so the run sees the new word
                if (l_we) begin
                    l_d[l_addr] = l_data;
                end
                if (start) begin
                    state_d     = ST_INIT;
                    i_d         = '0;
                    key_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_INIT: begin
                if (i_q == '0) begin
                    s_d[0] = P;
                end else begin
                    s_d[i_q] = s_q[i_q - 1'b1] + Q;
                end
                if (i_q == i_last) begin
                    state_d = ST_MIX;
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_MIX: begin
                s_d[i_q] = a_new;
                a_d      = a_new;
                l_d[j_q] = b_new;
                b_d      = b_new;
                i_d      = (i_q == i_last) ? '0 : i_q + 1'b1;
                j_d      = (j_q == j_last) ? '0 : j_q + 1'b1;
                k_d      = k_q + 1'b1;
                // done and key_valid rise together on the edge that leaves MIX
                if (k_q == k_last) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            for (int n = 0; n < t; n++) begin
                s_q[n] <= '0;
            end
            for (int n = 0; n < c; n++) begin
                l_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            l_q         <= l_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign s_rdata   = (s_raddr <= i_last) ? s_q[s_raddr] : '0;

endmodule

// File: tb/tb_rc5_key_mixer.sv
// Directed bench for rc5_key_mixer: probe table for the zero-key run, key table for full runs
// against a software RC5-32/12/16 schedule, plus hand-written corner sequences.
module tb_rc5_key_mixer;

    localparam logic [31:0] P_CONST = 32'hB7E15163;
    localparam logic [31:0] Q_CONST = 32'h9E3779B9;
    localparam int DONE_CYCLE = 105;

    logic        clk2 = 1'b0;
    logic        rst = 1'b1;
    logic        l_we = 1'b0;
    logic [1:0]  l_addr = '0;
    logic [31:0] l_data = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        key_valid;
    logic [4:0]  s_raddr = '0;
    logic [31:0] s_rdata;

    int n_vectors = 0;
    int n_miscompares = 0;
    int overlap_count = 0;
    logic [31:0] model_s [26];

    typedef struct {
        string       name;
        int          cycle;
        int          sel;
        logic [31:0] expected;
    } probe_t;

    typedef struct {
        string        name;
        logic [127:0] key;
    } key_vec_t;

    probe_t   probes [10];
    key_vec_t keys [5];

    rc5_key_mixer dut (
        .clk2      (clk2),
        .rst       (rst),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .s_raddr   (s_raddr),
        .s_rdata   (s_rdata)
    );

    always #5 clk2 = ~clk2;

    always @(negedge clk2) begin
        if (busy && done) overlap_count++;
    end

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference RC5 schedule, written as the textbook software loop
    task automatic computeModel(input logic [127:0] key);
        logic [31:0] lw [4];
        logic [31:0] a;
        logic [31:0] b;
        int ii;
        int jj;
        for (int n = 0; n < 4; n++) lw[n] = key[32*n +: 32];
        model_s[0] = P_CONST;
        for (int n = 1; n < 26; n++) model_s[n] = model_s[n-1] + Q_CONST;
        a = '0; b = '0; ii = 0; jj = 0;
        for (int n = 0; n < 78; n++) begin
            a = rotl32(model_s[ii] + a + b, 3);
            model_s[ii] = a;
            b = rotl32(lw[jj] + a + b, int'((a + b) & 32'd31));
            lw[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [31:0] data, input logic st);
        l_we = we; l_addr = addr; l_data = data; start = st;
        @(posedge clk2); #1;
        l_we = 1'b0; start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk2); #1;
    endtask

    task automatic loadKey(input logic [127:0] key, input int words);
        for (int n = 0; n < words; n++) applyStimulus(1'b1, 2'(n), key[32*n +: 32], 1'b0);
    endtask

    // Cycle 1 is the period right after the edge that samples start
    task automatic waitDone(input int cyc_in, output int cyc_out);
        int cyc;
        cyc = cyc_in;
        while (done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        cyc_out = cyc;
    endtask

    task automatic checkSTable(input string tag, input logic [127:0] key);
        computeModel(key);
        for (int a = 0; a < 32; a++) begin
            s_raddr = 5'(a);
            #1;
            checkOutput($sformatf("%s_s%0d", tag, a), s_rdata, (a < 26) ? model_s[a] : 32'h0);
        end
    endtask

    task automatic finishRun(input string tag, input logic [127:0] key, input int cyc_in);
        int cyc;
        waitDone(cyc_in, cyc);
        checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(DONE_CYCLE));
        checkOutput({tag, "_busy_at_done"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, "_kv_at_done"}, {31'b0, key_valid}, 32'h1);
        tick();
        checkOutput({tag, "_done_pulse_end"}, {31'b0, done}, 32'h0);
        checkOutput({tag, "_kv_hold"}, {31'b0, key_valid}, 32'h1);
        checkSTable(tag, key);
    endtask

    function automatic logic [31:0] probeValue(input int sel);
        case (sel)
            0:       return dut.s_q[0];
            1:       return dut.s_q[1];
            2:       return dut.s_q[2];
            3:       return dut.a_q;
            4:       return dut.l_q[0];
            5:       return dut.b_q;
            6:       return {31'b0, busy};
            default: return {31'b0, done};
        endcase
    endfunction

    initial begin
        int cyc;
        logic [127:0] k_a;
        logic [127:0] k_b;

        probes[0] = '{"busy_c1",   1,   6, 32'h1};
        probes[1] = '{"s0_init",   27,  0, 32'hB7E15163};
        probes[2] = '{"s1_init",   27,  1, 32'h5618CB1C};
        probes[3] = '{"s2_init",   27,  2, 32'hF45044D5};
        probes[4] = '{"s0_mix1",   28,  0, 32'hBF0A8B1D};
        probes[5] = '{"a_mix1",    28,  3, 32'hBF0A8B1D};
        probes[6] = '{"l0_mix1",   28,  4, 32'hB7E15163};
        probes[7] = '{"b_mix1",    28,  5, 32'hB7E15163};
        probes[8] = '{"busy_c104", 104, 6, 32'h1};
        probes[9] = '{"done_c104", 104, 7, 32'h0};

        keys[0] = '{"zero", 128'h0};
        keys[1] = '{"ones", {4{32'hFFFFFFFF}}};
        keys[2] = '{"seq",  128'h0F0E0D0C_0B0A0908_07060504_03020100};
        keys[3] = '{"rnda", 128'h915F4619_BE41B251_6355A50D_52C9C6EA};
        keys[4] = '{"rndb", 128'h5A17C0DE_0123ABCD_DEADBEEF_8000_0001};
        k_a = 128'hC0FFEE00_11223344_A5A5A5A5_7F7F0001;
        k_b = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;

        $display("[TB] reset and idle");
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'd0, 32'hFFFFFFFF, 1'b1);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_done", {31'b0, done}, 32'h0);
        checkOutput("rst_kv", {31'b0, key_valid}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            s_raddr = 5'(a);
            #1;
            checkOutput($sformatf("rst_s%0d", a), s_rdata, 32'h0);
        end
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("idle_busy", {31'b0, busy}, 32'h0);
        checkOutput("idle_done", {31'b0, done}, 32'h0);
        checkOutput("idle_kv", {31'b0, key_valid}, 32'h0);
        checkOutput("idle_l0", dut.l_q[0], 32'h0);

        $display("[TB] zero-key probe run");
        loadKey(128'h0, 4);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        cyc = 1;
        for (int p = 0; p < 10; p++) begin
            while (cyc < probes[p].cycle) begin
                tick();
                cyc++;
            end
            checkOutput(probes[p].name, probeValue(probes[p].sel), probes[p].expected);
        end
        finishRun("probe", 128'h0, cyc);

        $display("[TB] key table");
        for (int v = 0; v < 5; v++) begin
            loadKey(keys[v].key, 4);
            applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
            checkOutput({keys[v].name, "_kv_cleared"}, {31'b0, key_valid}, 32'h0);
            finishRun(keys[v].name, keys[v].key, 1);
        end

        $display("[TB] same-cycle write+start, start during MIX");
        loadKey(k_a, 3);
        applyStimulus(1'b1, 2'd3, k_a[127:96], 1'b1);
        cyc = 1;
        while (cyc < 60) begin
            tick();
            cyc++;
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        cyc++;
        finishRun("restart", k_a, cyc);

        $display("[TB] l_we during INIT");
        loadKey(k_b, 4);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        cyc = 1;
        while (cyc < 5) begin
            tick();
            cyc++;
        end
        applyStimulus(1'b1, 2'd2, 32'hFFFFFFFF, 1'b0);
        cyc++;
        finishRun("initwr", k_b, cyc);

        $display("[TB] reset mid-MIX");
        loadKey(k_a, 4);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        cyc = 1;
        while (cyc < 50) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
        checkOutput("midrst_kv", {31'b0, key_valid}, 32'h0);
        checkOutput("midrst_done", {31'b0, done}, 32'h0);
        s_raddr = 5'd0;
        #1;
        checkOutput("midrst_s0", s_rdata, 32'h0);
        rst = 1'b0;
        tick();
        loadKey(k_b, 4);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        finishRun("afterrst", k_b, 1);

        checkOutput("busy_done_overlap", 32'(overlap_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
